// File: rtl/easyaxi_rd_slice.sv
// easyaxi_rd_slice: registered AXI read-path slice with a 2-entry skid buffer
// on the AR (forward) and R (backward) channels, plus an outstanding-burst
// counter that throttles AR acceptance at MAX_OST.

// Generic 2-entry skid buffer: main stage drives the output, skid catches a
// beat that arrives while main is stalled. in_ready is a pure register.
module easyaxi_rd_slice_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         allow,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         main_free;
  logic         main_valid_n;
  logic         skid_valid_n;
  logic         load_main;
  logic         load_skid;
  logic         take_skid;

  // Next-state for main/skid occupancy and which register loads what.
  always_comb begin
    main_valid_n = out_valid;
    skid_valid_n = skid_valid;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    take_skid    = 1'b0;
    in_fire      = in_valid & in_ready;
    main_free    = ~out_valid | out_ready;
    if (main_free) begin
      if (skid_valid) begin
        // Skid is older than anything arriving now; in_ready is 0 here.
        main_valid_n = 1'b1;
        skid_valid_n = 1'b0;
        take_skid    = 1'b1;
      end else begin
        main_valid_n = in_fire;
        load_main    = in_fire;
      end
    end else if (in_fire) begin
      skid_valid_n = 1'b1;
      load_skid    = 1'b1;
    end
  end

  // Control registers; ready is precomputed from next-cycle skid occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= main_valid_n;
      skid_valid <= skid_valid_n;
      in_ready   <= ~skid_valid_n & allow;
    end
  end

  // Payload registers; only meaningful while the matching valid is set.
  always_ff @(posedge clk) begin
    if (take_skid) begin
      out_data <= skid_data;
    end else if (load_main) begin
      out_data <= in_data;
    end
    if (load_skid) begin
      skid_data <= in_data;
    end
  end

endmodule

module easyaxi_rd_slice #(
  parameter int unsigned AR_W    = 50,
  parameter int unsigned R_W     = 40,
  parameter int unsigned MAX_OST = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  input  logic [AR_W-1:0]                s_ar,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [R_W-1:0]                 s_r,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  output logic [AR_W-1:0]                m_ar,
  input  logic                           m_rvalid,
  output logic                           m_rready,
  input  logic [R_W-1:0]                 m_r,
  output logic [$clog2(MAX_OST+1)-1:0]   ost_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_OST + 1);

  logic             inc;
  logic             dec;
  logic             ar_allow;
  logic [CNT_W-1:0] cnt_next;

  // Outstanding-burst count: +1 on AR accept, -1 on upstream rlast, saturating.
  always_comb begin
    inc      = s_arvalid & s_arready;
    dec      = s_rvalid & s_rready & s_r[0] & (ost_cnt != CNT_W'(0));
    cnt_next = ost_cnt;
    if (inc && !dec && (ost_cnt != CNT_W'(MAX_OST))) begin
      cnt_next = ost_cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_next = ost_cnt - CNT_W'(1);
    end
    ar_allow = (cnt_next != CNT_W'(MAX_OST));
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ost_cnt <= CNT_W'(0);
    end else begin
      ost_cnt <= cnt_next;
    end
  end

  easyaxi_rd_slice_skid #(.W(AR_W)) u_ar (
    .clk       (clk),
    .rst       (rst),
    .allow     (ar_allow),
    .in_valid  (s_arvalid),
    .in_ready  (s_arready),
    .in_data   (s_ar),
    .out_valid (m_arvalid),
    .out_ready (m_arready),
    .out_data  (m_ar)
  );

  easyaxi_rd_slice_skid #(.W(R_W)) u_r (
    .clk       (clk),
    .rst       (rst),
    .allow     (1'b1),
    .in_valid  (m_rvalid),
    .in_ready  (m_rready),
    .in_data   (m_r),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_data  (s_r)
  );

endmodule

// File: tb/tb_easyaxi_rd_slice.sv
// Directed self-checking bench for easyaxi_rd_slice.
// Inputs are driven and outputs sampled on the falling edge.
module tb_easyaxi_rd_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_arvalid;
  logic        s_arready;
  logic [49:0] s_ar;
  logic        s_rvalid;
  logic        s_rready;
  logic [39:0] s_r;
  logic        m_arvalid;
  logic        m_arready;
  logic [49:0] m_ar;
  logic        m_rvalid;
  logic        m_rready;
  logic [39:0] m_r;
  logic [4:0]  ost_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  easyaxi_rd_slice dut (
    .clk       (clk),
    .rst       (rst),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_ar      (s_ar),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_r       (s_r),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_ar      (m_ar),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_r       (m_r),
    .ost_cnt   (ost_cnt)
  );

  // AR payload {arid, araddr, arlen, arsize, arburst, aruser}
  function automatic logic [49:0] mk_ar(input int i, input logic [7:0] len);
    mk_ar = {4'(i), 32'h2000 + 32'(i * 16), len, 3'd2, 2'd1, 1'b0};
  endfunction

  // R payload {rid, rdata, rresp, ruser, rlast}
  function automatic logic [39:0] mk_r(input int id, input logic [31:0] d, input logic last);
    mk_r = {4'(id), d, 2'b00, 1'b0, last};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_arvalid = 1'b0; s_ar = '0; s_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_r = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    s_arvalid = 1'b0; s_ar = '0; s_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_r = '0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({m_arvalid, s_rvalid, s_arready, m_rready} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000", {m_arvalid, s_rvalid, s_arready, m_rready});
    end
    tests++;
    if (ost_cnt !== 5'd0) begin
      fails++;
      $display("FAIL reset_ost: got %0d want 0", ost_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_arready, m_rready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 11", {s_arready, m_rready});
    end
  endtask

  task automatic test_single();
    logic [49:0] a;
    logic [39:0] r;
    do_reset();
    a = {4'd3, 32'h0000_1000, 8'd0, 3'd2, 2'd1, 1'b1};
    r = mk_r(3, 32'hDEAD_BEEF, 1'b1);
    m_arready = 1'b1;
    s_arvalid = 1'b1; s_ar = a;
    @(negedge clk);
    s_arvalid = 1'b0;
    tests++;
    if (m_arvalid !== 1'b1 || m_ar !== a || ost_cnt !== 5'd1) begin
      fails++;
      $display("FAIL single_ar: got v=%b ar=%h ost=%0d want v=1 ar=%h ost=1", m_arvalid, m_ar, ost_cnt, a);
    end
    @(negedge clk);
    tests++;
    if (m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_ar_drain: got %b want 0", m_arvalid);
    end
    m_rvalid = 1'b1; m_r = r; s_rready = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0;
    tests++;
    if (s_rvalid !== 1'b1 || s_r !== r || ost_cnt !== 5'd1) begin
      fails++;
      $display("FAIL single_r: got v=%b r=%h ost=%0d want v=1 r=%h ost=1", s_rvalid, s_r, ost_cnt, r);
    end
    @(negedge clk);
    tests++;
    if (s_rvalid !== 1'b0 || ost_cnt !== 5'd0) begin
      fails++;
      $display("FAIL single_r_done: got v=%b ost=%0d want v=0 ost=0", s_rvalid, ost_cnt);
    end
  endtask

  task automatic test_ost_limit();
    do_reset();
    m_arready = 1'b1; s_rready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (s_arready !== 1'b1) begin
        fails++;
        $display("FAIL ost_accept_ready[%0d]: got %b want 1", i, s_arready);
      end
      s_arvalid = 1'b1; s_ar = mk_ar(i, 8'd0);
      @(negedge clk);
      tests++;
      if (m_arvalid !== 1'b1 || m_ar !== mk_ar(i, 8'd0)) begin
        fails++;
        $display("FAIL ost_fwd[%0d]: got v=%b ar=%h want v=1 ar=%h", i, m_arvalid, m_ar, mk_ar(i, 8'd0));
      end
    end
    s_ar = mk_ar(16, 8'd0);
    tests++;
    if (ost_cnt !== 5'd16 || s_arready !== 1'b0) begin
      fails++;
      $display("FAIL ost_full: got ost=%0d rdy=%b want ost=16 rdy=0", ost_cnt, s_arready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (ost_cnt !== 5'd16 || s_arready !== 1'b0) begin
        fails++;
        $display("FAIL ost_hold[%0d]: got ost=%0d rdy=%b want ost=16 rdy=0", k, ost_cnt, s_arready);
      end
    end
    m_rvalid = 1'b1; m_r = mk_r(0, 32'h1111_0000, 1'b1); s_rready = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0;
    tests++;
    if (s_rvalid !== 1'b1 || s_arready !== 1'b0) begin
      fails++;
      $display("FAIL ost_r_pending: got v=%b rdy=%b want v=1 rdy=0", s_rvalid, s_arready);
    end
    @(negedge clk);
    tests++;
    if (s_arready !== 1'b1 || ost_cnt !== 5'd15) begin
      fails++;
      $display("FAIL ost_release: got rdy=%b ost=%0d want rdy=1 ost=15", s_arready, ost_cnt);
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    tests++;
    if (ost_cnt !== 5'd16 || m_arvalid !== 1'b1 || m_ar !== mk_ar(16, 8'd0)) begin
      fails++;
      $display("FAIL ost_17th: got ost=%0d v=%b ar=%h want ost=16 v=1 ar=%h", ost_cnt, m_arvalid, m_ar, mk_ar(16, 8'd0));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_arready = 1'b0;
    s_arvalid = 1'b1; s_ar = mk_ar(10, 8'd0);
    @(negedge clk);
    s_ar = mk_ar(11, 8'd0);
    tests++;
    if (s_arready !== 1'b1 || m_ar !== mk_ar(10, 8'd0)) begin
      fails++;
      $display("FAIL bp_first: got rdy=%b ar=%h want rdy=1 ar=%h", s_arready, m_ar, mk_ar(10, 8'd0));
    end
    @(negedge clk);
    s_ar = mk_ar(12, 8'd0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (s_arready !== 1'b0 || m_arvalid !== 1'b1 || m_ar !== mk_ar(10, 8'd0)) begin
        fails++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b ar=%h want rdy=0 v=1 ar=%h", k, s_arready, m_arvalid, m_ar, mk_ar(10, 8'd0));
      end
      @(negedge clk);
    end
    m_arready = 1'b1;
    @(negedge clk);
    tests++;
    if (m_arvalid !== 1'b1 || m_ar !== mk_ar(11, 8'd0) || s_arready !== 1'b1) begin
      fails++;
      $display("FAIL bp_B: got v=%b ar=%h rdy=%b want v=1 ar=%h rdy=1", m_arvalid, m_ar, s_arready, mk_ar(11, 8'd0));
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    tests++;
    if (m_arvalid !== 1'b1 || m_ar !== mk_ar(12, 8'd0)) begin
      fails++;
      $display("FAIL bp_C: got v=%b ar=%h want v=1 ar=%h", m_arvalid, m_ar, mk_ar(12, 8'd0));
    end
    @(negedge clk);
    tests++;
    if (m_arvalid !== 1'b0 || ost_cnt !== 5'd3) begin
      fails++;
      $display("FAIL bp_end: got v=%b ost=%0d want v=0 ost=3", m_arvalid, ost_cnt);
    end
  endtask

  task automatic test_burst();
    logic [39:0] beats [4];
    logic [15:0] pat;
    int m_in, k_out, cyc;
    logic [4:0] exp_ost;
    logic m_fire, s_fire;
    do_reset();
    for (int b = 0; b < 4; b++) beats[b] = mk_r(2, 32'h0000_00A0 + 32'(b), (b == 3));
    pat = 16'b0110_1001_1101_0011;
    m_arready = 1'b1;
    s_arvalid = 1'b1; s_ar = mk_ar(2, 8'd3);
    @(negedge clk);
    s_arvalid = 1'b0;
    exp_ost = 5'd1; m_in = 0; k_out = 0; cyc = 0;
    while (k_out < 4 && cyc < 40) begin
      tests++;
      if (ost_cnt !== exp_ost) begin
        fails++;
        $display("FAIL burst_ost[cyc %0d]: got %0d want %0d", cyc, ost_cnt, exp_ost);
      end
      s_rready = pat[cyc % 16];
      if (m_in < 4) begin
        m_rvalid = 1'b1; m_r = beats[m_in];
      end else begin
        m_rvalid = 1'b0;
      end
      m_fire = m_rvalid && m_rready;
      s_fire = s_rvalid && s_rready;
      if (s_fire) begin
        tests++;
        if (s_r !== beats[k_out]) begin
          fails++;
          $display("FAIL burst_beat[%0d]: got %h want %h", k_out, s_r, beats[k_out]);
        end
        if (k_out == 3) exp_ost = 5'd0;
        k_out++;
      end
      if (m_fire) m_in++;
      @(negedge clk);
      cyc++;
    end
    m_rvalid = 1'b0; s_rready = 1'b0;
    tests++;
    if (k_out != 4) begin
      fails++;
      $display("FAIL burst_timeout: got %0d beats want 4", k_out);
    end
    tests++;
    if (ost_cnt !== 5'd0) begin
      fails++;
      $display("FAIL burst_final_ost: got %0d want 0", ost_cnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_arvalid = 1'b1; s_ar = mk_ar(i, 8'd0);
      @(negedge clk);
    end
    s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_r = mk_r(0, 32'h5555_5555, 1'b1); s_rready = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b0;
    tests++;
    if (ost_cnt !== 5'd5 || s_rvalid !== 1'b1 || s_arready !== 1'b1) begin
      fails++;
      $display("FAIL simul_setup: got ost=%0d rv=%b ardy=%b want ost=5 rv=1 ardy=1", ost_cnt, s_rvalid, s_arready);
    end
    s_rready = 1'b1; s_arvalid = 1'b1; s_ar = mk_ar(5, 8'd0);
    @(negedge clk);
    s_arvalid = 1'b0; s_rready = 1'b0;
    tests++;
    if (ost_cnt !== 5'd5 || s_rvalid !== 1'b0 || m_ar !== mk_ar(5, 8'd0)) begin
      fails++;
      $display("FAIL simul_ost: got ost=%0d rv=%b ar=%h want ost=5 rv=0 ar=%h", ost_cnt, s_rvalid, m_ar, mk_ar(5, 8'd0));
    end
  endtask

  task automatic test_underflow();
    do_reset();
    m_rvalid = 1'b1; m_r = mk_r(7, 32'h0BAD_0BAD, 1'b1); s_rready = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (ost_cnt !== 5'd0 || s_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL underflow: got ost=%0d rv=%b want ost=0 rv=0", ost_cnt, s_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [49:0] a;
    do_reset();
    m_arready = 1'b0; s_rready = 1'b0;
    s_arvalid = 1'b1; s_ar = mk_ar(1, 8'd0);
    m_rvalid = 1'b1; m_r = mk_r(1, 32'h0000_0001, 1'b0);
    @(negedge clk);
    s_ar = mk_ar(2, 8'd0);
    m_r = mk_r(1, 32'h0000_0002, 1'b1);
    @(negedge clk);
    s_arvalid = 1'b0; m_rvalid = 1'b0;
    tests++;
    if ({s_arready, m_rready, m_arvalid, s_rvalid} !== 4'b0011 || ost_cnt !== 5'd2) begin
      fails++;
      $display("FAIL mid_full: got %b ost=%0d want 0011 ost=2", {s_arready, m_rready, m_arvalid, s_rvalid}, ost_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({m_arvalid, s_rvalid, s_arready, m_rready} !== 4'b0000 || ost_cnt !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset: got %b ost=%0d want 0000 ost=0", {m_arvalid, s_rvalid, s_arready, m_rready}, ost_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({s_arready, m_rready, m_arvalid, s_rvalid} !== 4'b1100) begin
      fails++;
      $display("FAIL mid_release: got %b want 1100", {s_arready, m_rready, m_arvalid, s_rvalid});
    end
    a = mk_ar(9, 8'd1);
    m_arready = 1'b1;
    s_arvalid = 1'b1; s_ar = a;
    @(negedge clk);
    s_arvalid = 1'b0;
    tests++;
    if (m_arvalid !== 1'b1 || m_ar !== a || ost_cnt !== 5'd1) begin
      fails++;
      $display("FAIL mid_resume: got v=%b ar=%h ost=%0d want v=1 ar=%h ost=1", m_arvalid, m_ar, ost_cnt, a);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_arvalid = 1'b0; s_ar = '0; s_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_r = '0;
    test_reset();
    test_single();
    test_ost_limit();
    test_backpressure();
    test_burst();
    test_simultaneous();
    test_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
